// File: rtl/pcie_ss_axis_arb_pkg.sv
// Shared types and helpers for the PCIe SS AXI-Stream packet arbiter.
//   t_axis_beat : one stream beat plus the index of the source it came from
//   t_arb_state : arbiter lock state
//   rr_pick     : round-robin search starting one past a pointer
// The arbiter top defaults its parameters to the localparams here; the beat
// struct is built from them, so any override must be made here as well.
package pcie_ss_axis_arb_pkg;

  localparam int ARB_PORTS  = 4;
  localparam int ARB_DATA_W = 512;
  localparam int ARB_USER_W = 10;
  localparam int ARB_KEEP_W = ARB_DATA_W / 8;
  localparam int ARB_SRC_W  = $clog2(ARB_PORTS);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic [ARB_DATA_W-1:0] tdata;
    logic [ARB_KEEP_W-1:0] tkeep;
    logic                  tlast;
    logic [ARB_USER_W-1:0] tuser;
    logic [ARB_SRC_W-1:0]  src;
  } t_axis_beat;

  // First requesting index found searching ptr+1, ptr+2, ... with wrap.
  // The pointer itself is examined last. Returns ptr when req is empty,
  // so callers must qualify the result with |req.
  function automatic logic [ARB_SRC_W-1:0] rr_pick(
    input logic [ARB_PORTS-1:0] req,
    input logic [ARB_SRC_W-1:0] ptr
  );
    logic                 found;
    logic [ARB_SRC_W-1:0] idx;
    logic [ARB_SRC_W-1:0] pick;
    found = 1'b0;
    pick  = ptr;
    for (int k = 1; k <= ARB_PORTS; k++) begin
      idx = ARB_SRC_W'((int'(ptr) + k) % ARB_PORTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_skid.sv
// Two-entry AXI-Stream register slice carrying t_axis_beat.
// The output register is the first entry and a skid register the second, so
// out_* come straight from flops and in_ready is the inverse of a flop.
// Sustains one beat per cycle while out_ready stays high.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_beat payload
//   out_valid/out_ready  : downstream handshake, out_beat payload
module pcie_ss_axis_skid
  import pcie_ss_axis_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  t_axis_beat in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output t_axis_beat out_beat
);

  logic       skid_vld;
  t_axis_beat skid_beat;

  // Upstream may only push while the skid entry is free; a push in that
  // state always has somewhere to land even if out_ready drops.
  assign in_ready = !skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
      skid_vld  <= 1'b0;
      skid_beat <= '0;
    end else if (!out_valid || out_ready) begin
      // Output register free this cycle: drain skid first to keep order.
      if (skid_vld) begin
        out_beat  <= skid_beat;
        out_valid <= 1'b1;
        skid_vld  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_beat <= in_beat;
      end
    end else if (in_valid && in_ready) begin
      // Output stalled: park the accepted beat.
      skid_beat <= in_beat;
      skid_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/pcie_ss_axis_pkt_arb.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream sources
// onto one sink. A grant is held from first beat to tlast, so beats of
// different packets never interleave. Output goes through a 2-entry skid.
//   clk, rst_n            : clock, asynchronous active-low reset
//   port_en               : per-port arbitration enable (quasi-static)
//   in_t*                 : per-port source streams
//   out_t*, out_src       : merged stream, out_src = originating port
//   busy                  : a packet grant is held
module pcie_ss_axis_pkt_arb
  import pcie_ss_axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = ARB_PORTS,
  parameter int DATA_WIDTH = ARB_DATA_W,
  parameter int USER_WIDTH = ARB_USER_W,
  parameter int SRC_W      = $clog2(NUM_PORTS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_PORTS-1:0]                   port_en,
  input  logic [NUM_PORTS-1:0]                   in_tvalid,
  output logic [NUM_PORTS-1:0]                   in_tready,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [NUM_PORTS-1:0]                   in_tlast,
  input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0]   in_tuser,
  output logic                                   out_tvalid,
  input  logic                                   out_tready,
  output logic [DATA_WIDTH-1:0]                  out_tdata,
  output logic [DATA_WIDTH/8-1:0]                out_tkeep,
  output logic                                   out_tlast,
  output logic [USER_WIDTH-1:0]                  out_tuser,
  output logic [SRC_W-1:0]                       out_src,
  output logic                                   busy
);

  t_arb_state           state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     last_q, last_d;
  logic [NUM_PORTS-1:0] elig, elig_oth, gmask;
  logic                 skid_rdy, skid_in_vld, acc;
  t_axis_beat           in_beat, out_beat;

  assign elig = in_tvalid & port_en;

  always_comb begin
    gmask          = '0;
    gmask[grant_q] = 1'b1;
  end

  // At a tlast accept the held port's tvalid still belongs to the beat just
  // taken and says nothing about a following packet, so it is left out of
  // the same-cycle search. If nobody else is waiting it re-enters via IDLE,
  // where the pointer (now its own index) ranks it last - i.e. it only wins
  // when it is the sole requester.
  assign elig_oth = elig & ~gmask;

  assign skid_in_vld = (state_q == ARB_LOCKED) && in_tvalid[grant_q];
  assign acc         = skid_in_vld && skid_rdy;
  assign busy        = (state_q == ARB_LOCKED);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdy
    assign in_tready[i] = (state_q == ARB_LOCKED) && (grant_q == SRC_W'(i)) && skid_rdy;
  end

  always_comb begin
    in_beat       = '0;
    in_beat.tdata = in_tdata[grant_q];
    in_beat.tkeep = in_tkeep[grant_q];
    in_beat.tlast = in_tlast[grant_q];
    in_beat.tuser = in_tuser[grant_q];
    in_beat.src   = grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= SRC_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        // Arbitration cycle only; no beat is taken until LOCKED.
        if (|elig) begin
          grant_d = rr_pick(elig, last_q);
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        // port_en is ignored here: a started packet always completes.
        if (acc && in_tlast[grant_q]) begin
          last_d = grant_q;
          if (|elig_oth) grant_d = rr_pick(elig_oth, grant_q);
          else           state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  pcie_ss_axis_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (skid_in_vld),
    .in_ready  (skid_rdy),
    .in_beat   (in_beat),
    .out_valid (out_tvalid),
    .out_ready (out_tready),
    .out_beat  (out_beat)
  );

  assign out_tdata = out_beat.tdata;
  assign out_tkeep = out_beat.tkeep;
  assign out_tlast = out_beat.tlast;
  assign out_tuser = out_beat.tuser;
  assign out_src   = out_beat.src;

endmodule
